// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves up to LANES branch instructions per cycle (lane 0 oldest), detects
// mispredictions, raises a registered single-cycle flush for the oldest
// mispredicted lane and queues predictor-update records for every surviving
// branch lane into a small multi-push / single-pop FIFO.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   flush_i          : external flush, kills every lane this cycle
//   valid_i          : per-lane instruction valid
//   pc_i, inst_i     : per-lane pc and raw instruction (32 bits per lane)
//   reg1_i, reg2_i   : per-lane operands
//   aluop_i          : per-lane ALU opcode (8 bits per lane)
//   pre_taken_i      : per-lane predicted direction
//   pre_addr_i       : per-lane predicted target
//   stall_o          : fewer than LANES free update slots, inputs ignored
//   flush_o          : registered flush pulse
//   flush_target_o   : actual next pc of the flushing lane
//   flush_lane_o     : index of the flushing lane
//   link_o           : registered pc+4 per lane
//   upd_*            : predictor-update FIFO head (valid/ready handshake)
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int unsigned LANES     = 2,
    parameter int unsigned UPD_DEPTH = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         flush_i,
    input  logic [LANES-1:0]                             valid_i,
    input  logic [32*LANES-1:0]                          pc_i,
    input  logic [32*LANES-1:0]                          inst_i,
    input  logic [32*LANES-1:0]                          reg1_i,
    input  logic [32*LANES-1:0]                          reg2_i,
    input  logic [32*LANES-1:0]                          pre_addr_i,
    input  logic [8*LANES-1:0]                           aluop_i,
    input  logic [LANES-1:0]                             pre_taken_i,
    output logic                                         stall_o,
    output logic                                         flush_o,
    output logic [31:0]                                  flush_target_o,
    output logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] flush_lane_o,
    output logic [32*LANES-1:0]                          link_o,
    output logic                                         upd_valid_o,
    input  logic                                         upd_ready_i,
    output logic [31:0]                                  upd_pc_o,
    output logic [31:0]                                  upd_target_o,
    output logic                                         upd_taken_o,
    output logic                                         upd_call_o,
    output logic                                         upd_ret_o
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PW = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
    localparam int unsigned CW = $clog2(UPD_DEPTH) + 1;

    // ALU opcode encodings shared with the decode stage
    localparam logic [7:0] OP_BEQ   = 8'h50;
    localparam logic [7:0] OP_BNE   = 8'h51;
    localparam logic [7:0] OP_BLT   = 8'h52;
    localparam logic [7:0] OP_BGE   = 8'h53;
    localparam logic [7:0] OP_BLTU  = 8'h54;
    localparam logic [7:0] OP_BGEU  = 8'h55;
    localparam logic [7:0] OP_B     = 8'h56;
    localparam logic [7:0] OP_BL    = 8'h57;
    localparam logic [7:0] OP_JIRL  = 8'h58;
    localparam logic [7:0] OP_CACOP = 8'h59;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        call;
        logic        ret;
    } upd_entry_t;

    // ---------------------------------------------------------------- decode
    logic [7:0]       op_w     [LANES];
    logic [31:0]      pc_w     [LANES];
    logic [31:0]      inst_w   [LANES];
    logic [31:0]      r1_w     [LANES];
    logic [31:0]      r2_w     [LANES];
    logic [31:0]      pa_w     [LANES];
    logic [31:0]      offs16_w [LANES];
    logic [31:0]      offs26_w [LANES];
    logic [31:0]      lane_target [LANES];
    logic [31:0]      lane_next   [LANES];
    logic [LANES-1:0] lane_is_br;
    logic [LANES-1:0] lane_cond;
    logic [LANES-1:0] lane_taken;
    logic [LANES-1:0] lane_mispred;
    logic [LANES-1:0] lane_call;
    logic [LANES-1:0] lane_ret;
    logic [6*LANES-1:0] unused_inst_hi;

    always_comb begin
        lane_is_br     = '0;
        lane_cond      = '0;
        lane_taken     = '0;
        lane_mispred   = '0;
        lane_call      = '0;
        lane_ret       = '0;
        unused_inst_hi = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            op_w[l]   = aluop_i[8*l +: 8];
            pc_w[l]   = pc_i[32*l +: 32];
            inst_w[l] = inst_i[32*l +: 32];
            r1_w[l]   = reg1_i[32*l +: 32];
            r2_w[l]   = reg2_i[32*l +: 32];
            pa_w[l]   = pre_addr_i[32*l +: 32];
            unused_inst_hi[6*l +: 6] = inst_w[l][31:26];

            offs16_w[l] = {{14{inst_w[l][25]}}, inst_w[l][25:10], 2'b00};
            offs26_w[l] = {{4{inst_w[l][9]}}, inst_w[l][9:0], inst_w[l][25:10], 2'b00};

            case (op_w[l])
                OP_BEQ:  begin lane_is_br[l] = 1'b1; lane_cond[l] = (r1_w[l] == r2_w[l]); end
                OP_BNE:  begin lane_is_br[l] = 1'b1; lane_cond[l] = (r1_w[l] != r2_w[l]); end
                OP_BLT:  begin lane_is_br[l] = 1'b1; lane_cond[l] = ($signed(r1_w[l]) <  $signed(r2_w[l])); end
                OP_BGE:  begin lane_is_br[l] = 1'b1; lane_cond[l] = ($signed(r1_w[l]) >= $signed(r2_w[l])); end
                OP_BLTU: begin lane_is_br[l] = 1'b1; lane_cond[l] = (r1_w[l] <  r2_w[l]); end
                OP_BGEU: begin lane_is_br[l] = 1'b1; lane_cond[l] = (r1_w[l] >= r2_w[l]); end
                OP_B, OP_BL, OP_JIRL: begin lane_is_br[l] = 1'b1; lane_cond[l] = 1'b1; end
                OP_CACOP: ;
                default: ;
            endcase

            if (op_w[l] == OP_JIRL)
                lane_target[l] = r1_w[l] + offs16_w[l];
            else if (op_w[l] == OP_B || op_w[l] == OP_BL)
                lane_target[l] = pc_w[l] + offs26_w[l];
            else
                lane_target[l] = pc_w[l] + offs16_w[l];

            lane_taken[l] = lane_is_br[l] & lane_cond[l];
            lane_next[l]  = lane_taken[l] ? lane_target[l] : pc_w[l] + 32'd4;

            // A non-branch predicted taken sent fetch somewhere wrong as well
            if (lane_is_br[l])
                lane_mispred[l] = (lane_taken[l] != pre_taken_i[l]) |
                                  (lane_taken[l] & (pa_w[l] != lane_target[l]));
            else
                lane_mispred[l] = pre_taken_i[l];

            lane_call[l] = (op_w[l] == OP_BL) |
                           ((op_w[l] == OP_JIRL) & (inst_w[l][4:0] == 5'd1));
            lane_ret[l]  = (op_w[l] == OP_JIRL) & (inst_w[l][4:0] == 5'd0) &
                           (inst_w[l][9:5] == 5'd1) & (inst_w[l][25:10] == 16'd0);
        end
    end

    // ------------------------------------------------------- winner / commit
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    upd_entry_t       fifo_q [UPD_DEPTH];
    upd_entry_t       fifo_d [UPD_DEPTH];

    logic             stall;
    logic             accept;
    logic             mis_found;
    logic [LW-1:0]    win_lane;
    logic [31:0]      win_next;
    logic [LANES-1:0] survive;
    logic [LANES-1:0] push_mask;

    // Occupancy before this cycle's pop decides the stall
    assign stall  = ~rst & (count_q > CW'(UPD_DEPTH - LANES));
    assign accept = ~rst & ~flush_i & ~stall;

    always_comb begin
        mis_found = 1'b0;
        win_lane  = '0;
        win_next  = '0;
        survive   = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            // The winner itself survives; everything younger is killed
            survive[l] = ~mis_found;
            if (!mis_found && valid_i[l] && lane_mispred[l]) begin
                mis_found = 1'b1;
                win_lane  = LW'(l);
                win_next  = lane_next[l];
            end
        end
        push_mask = {LANES{accept}} & valid_i & lane_is_br & survive;
    end

    // ------------------------------------------------------------ flush/link
    logic                  flush_q, flush_d;
    logic [31:0]           flush_target_q, flush_target_d;
    logic [LW-1:0]         flush_lane_q, flush_lane_d;
    logic [32*LANES-1:0]   link_q, link_d;

    always_comb begin
        flush_d        = accept & mis_found;
        flush_target_d = flush_d ? win_next : '0;
        flush_lane_d   = flush_d ? win_lane : '0;
        link_d         = '0;
        for (int unsigned l = 0; l < LANES; l++)
            link_d[32*l +: 32] = pc_w[l] + 32'd4;
    end

    // ------------------------------------------------------------------ FIFO
    logic          pop;
    logic [CW-1:0] push_cnt;
    logic [PW-1:0] wr_idx;

    assign pop = ~rst & (count_q != '0) & upd_ready_i;

    // Surviving branch lanes are packed into consecutive slots in lane order
    always_comb begin
        fifo_d   = fifo_q;
        push_cnt = '0;
        wr_idx   = wr_ptr_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (push_mask[l]) begin
                wr_idx = wr_ptr_q + PW'(push_cnt);
                fifo_d[wr_idx] = '{pc:     pc_w[l],
                                   target: lane_target[l],
                                   taken:  lane_taken[l],
                                   call:   lane_call[l],
                                   ret:    lane_ret[l]};
                push_cnt = push_cnt + CW'(1);
            end
        end
        wr_ptr_d = wr_ptr_q + PW'(push_cnt);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + push_cnt - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            flush_q        <= 1'b0;
            flush_target_q <= '0;
            flush_lane_q   <= '0;
            link_q         <= '0;
        end else begin
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            flush_q        <= flush_d;
            flush_target_q <= flush_target_d;
            flush_lane_q   <= flush_lane_d;
            link_q         <= link_d;
        end
    end

    // Storage needs no reset: occupancy alone qualifies its contents
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    // ---------------------------------------------------------------- outputs
    assign stall_o        = stall;
    assign flush_o        = ~rst & flush_q;
    assign flush_target_o = rst ? '0 : flush_target_q;
    assign flush_lane_o   = rst ? '0 : flush_lane_q;
    assign link_o         = rst ? '0 : link_q;
    assign upd_valid_o    = ~rst & (count_q != '0);
    assign upd_pc_o       = fifo_q[rd_ptr_q].pc;
    assign upd_target_o   = fifo_q[rd_ptr_q].target;
    assign upd_taken_o    = fifo_q[rd_ptr_q].taken;
    assign upd_call_o     = fifo_q[rd_ptr_q].call;
    assign upd_ret_o      = fifo_q[rd_ptr_q].ret;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam logic [7:0] OP_ADD   = 8'h00;
    localparam logic [7:0] OP_BEQ   = 8'h50;
    localparam logic [7:0] OP_BNE   = 8'h51;
    localparam logic [7:0] OP_BLT   = 8'h52;
    localparam logic [7:0] OP_BGE   = 8'h53;
    localparam logic [7:0] OP_BLTU  = 8'h54;
    localparam logic [7:0] OP_BGEU  = 8'h55;
    localparam logic [7:0] OP_B     = 8'h56;
    localparam logic [7:0] OP_BL    = 8'h57;
    localparam logic [7:0] OP_JIRL  = 8'h58;
    localparam logic [7:0] OP_CACOP = 8'h59;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [1:0]  valid_i;
    logic [63:0] pc_i, inst_i, reg1_i, reg2_i, pre_addr_i;
    logic [15:0] aluop_i;
    logic [1:0]  pre_taken_i;
    logic        stall_o, flush_o;
    logic [31:0] flush_target_o;
    logic [0:0]  flush_lane_o;
    logic [63:0] link_o;
    logic        upd_valid_o, upd_ready_i;
    logic [31:0] upd_pc_o, upd_target_o;
    logic        upd_taken_o, upd_call_o, upd_ret_o;

    branch_resolve_unit #(.LANES(2), .UPD_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i),
        .pc_i(pc_i), .inst_i(inst_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
        .pre_addr_i(pre_addr_i), .aluop_i(aluop_i), .pre_taken_i(pre_taken_i),
        .stall_o(stall_o), .flush_o(flush_o), .flush_target_o(flush_target_o),
        .flush_lane_o(flush_lane_o), .link_o(link_o),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i),
        .upd_pc_o(upd_pc_o), .upd_target_o(upd_target_o),
        .upd_taken_o(upd_taken_o), .upd_call_o(upd_call_o), .upd_ret_o(upd_ret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tg;
        logic        tk;
        logic        cl;
        logic        rt;
    } ent_t;

    typedef struct {
        logic [1:0]       valid;
        logic [1:0][7:0]  op;
        logic [1:0][31:0] pc, inst, r1, r2, pa;
        logic [1:0]       pt;
        logic             ef;
        logic [31:0]      et;
        logic             el;
        int               ne;
        logic [1:0][31:0] epc, etg;
        logic [1:0]       etk, ecl, ert;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    ent_t sb[$];
    vec_t tbl[9];
    vec_t z;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] i16(input logic [4:0] rd, input logic [4:0] rj, input logic [15:0] o);
        return {6'b010110, o, rj, rd};
    endfunction

    function automatic logic [31:0] i26(input logic [25:0] o);
        return {6'b010100, o[15:0], o[25:16]};
    endfunction

    function automatic vec_t ln(input vec_t v, input int l, input logic [7:0] op,
                                input logic [31:0] pc, input logic [31:0] inst,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic pt, input logic [31:0] pa);
        v.valid[l] = 1'b1; v.op[l] = op; v.pc[l] = pc; v.inst[l] = inst;
        v.r1[l] = r1; v.r2[l] = r2; v.pt[l] = pt; v.pa[l] = pa;
        return v;
    endfunction

    function automatic vec_t en(input vec_t v, input logic [31:0] pc, input logic [31:0] tg,
                                input logic tk, input logic cl, input logic rt);
        v.epc[v.ne] = pc; v.etg[v.ne] = tg; v.etk[v.ne] = tk; v.ecl[v.ne] = cl; v.ert[v.ne] = rt;
        v.ne++;
        return v;
    endfunction

    function automatic vec_t fl(input vec_t v, input logic [31:0] t, input logic l);
        v.ef = 1'b1; v.et = t; v.el = l;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        valid_i = v.valid; aluop_i = v.op; pc_i = v.pc; inst_i = v.inst;
        reg1_i = v.r1; reg2_i = v.r2; pre_addr_i = v.pa; pre_taken_i = v.pt;
    endtask

    task automatic idle();
        valid_i = '0; pre_taken_i = '0;
    endtask

    task automatic expect_entries(input vec_t v);
        for (int k = 0; k < v.ne; k++)
            sb.push_back('{pc: v.epc[k], tg: v.etg[k], tk: v.etk[k], cl: v.ecl[k], rt: v.ert[k]});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 50 && (upd_valid_o || sb.size() != 0); k++) step();
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({name, "_upd_valid"}, 64'(upd_valid_o), 64'd0);
    endtask

    // Two not-taken, correctly predicted BEQs starting at pc
    function automatic vec_t grp(input logic [31:0] pc);
        vec_t v;
        v = z;
        v = ln(v, 0, OP_BEQ, pc,       i16(0, 0, 16'd2), 32'd1, 32'd2, 1'b0, 32'd0);
        v = ln(v, 1, OP_BEQ, pc + 32'd4, i16(0, 0, 16'd2), 32'd1, 32'd2, 1'b0, 32'd0);
        v = en(v, pc,        pc + 32'd8,  1'b0, 1'b0, 1'b0);
        v = en(v, pc + 32'd4, pc + 32'd12, 1'b0, 1'b0, 1'b0);
        return v;
    endfunction

    // Scoreboard consumer: the head seen here pops on the next rising edge
    always @(negedge clk) begin
        if (!rst && upd_valid_o && upd_ready_i) begin
            if (sb.size() == 0) begin
                check("upd_unexpected", 64'(upd_pc_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                ent_t e;
                e = sb.pop_front();
                check("upd_pc", 64'(upd_pc_o), 64'(e.pc));
                check("upd_target", 64'(upd_target_o), 64'(e.tg));
                check("upd_tk_call_ret", 64'({upd_taken_o, upd_call_o, upd_ret_o}),
                      64'({e.tk, e.cl, e.rt}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        z = '{default: '0};

        // BEQ taken, predicted not taken
        tbl[0] = ln(z, 0, OP_BEQ, 32'h1C000000, i16(0, 0, 16'd4), 32'd5, 32'd5, 1'b0, 32'd0);
        tbl[0] = en(tbl[0], 32'h1C000000, 32'h1C000010, 1'b1, 1'b0, 1'b0);
        tbl[0] = fl(tbl[0], 32'h1C000010, 1'b0);
        // BLT signed taken, BLTU same operands not taken, both predicted right
        tbl[1] = ln(z, 0, OP_BLT, 32'h1C000100, i16(0, 0, 16'd8), 32'hFFFFFFFF, 32'd1, 1'b1, 32'h1C000120);
        tbl[1] = ln(tbl[1], 1, OP_BLTU, 32'h1C000104, i16(0, 0, 16'd8), 32'hFFFFFFFF, 32'd1, 1'b0, 32'd0);
        tbl[1] = en(tbl[1], 32'h1C000100, 32'h1C000120, 1'b1, 1'b0, 1'b0);
        tbl[1] = en(tbl[1], 32'h1C000104, 32'h1C000124, 1'b0, 1'b0, 1'b0);
        // lane0 BNE mispredicted, lane1 BL killed
        tbl[2] = ln(z, 0, OP_BNE, 32'h1C000200, i16(0, 0, 16'd4), 32'd3, 32'd3, 1'b1, 32'h1C000210);
        tbl[2] = ln(tbl[2], 1, OP_BL, 32'h1C000204, i26(26'd1), 32'd0, 32'd0, 1'b0, 32'd0);
        tbl[2] = en(tbl[2], 32'h1C000200, 32'h1C000210, 1'b0, 1'b0, 1'b0);
        tbl[2] = fl(tbl[2], 32'h1C000204, 1'b0);
        // JIRL return, predicted correctly
        tbl[3] = ln(z, 0, OP_JIRL, 32'h1C000300, i16(5'd0, 5'd1, 16'd0), 32'h1C000100, 32'd0, 1'b1, 32'h1C000100);
        tbl[3] = en(tbl[3], 32'h1C000300, 32'h1C000100, 1'b1, 1'b0, 1'b1);
        // lane0 non-branch, lane1 backward B mispredicted
        tbl[4] = ln(z, 0, OP_ADD, 32'h1C000400, 32'h0, 32'd0, 32'd0, 1'b0, 32'd0);
        tbl[4] = ln(tbl[4], 1, OP_B, 32'h1C000404, i26(26'h3FFFFFF), 32'd0, 32'd0, 1'b0, 32'd0);
        tbl[4] = en(tbl[4], 32'h1C000404, 32'h1C000400, 1'b1, 1'b0, 1'b0);
        tbl[4] = fl(tbl[4], 32'h1C000400, 1'b1);
        // CACOP predicted taken, younger BGE killed
        tbl[5] = ln(z, 0, OP_CACOP, 32'h1C000500, i16(0, 0, 16'd4), 32'd0, 32'd0, 1'b1, 32'h1C000510);
        tbl[5] = ln(tbl[5], 1, OP_BGE, 32'h1C000504, i16(0, 0, 16'd4), 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 32'd0);
        tbl[5] = fl(tbl[5], 32'h1C000504, 1'b0);
        // BGEU not taken, JIRL call with negative offset
        tbl[6] = ln(z, 0, OP_BGEU, 32'h1C000600, i16(0, 0, 16'd3), 32'd1, 32'hFFFFFFFF, 1'b0, 32'd0);
        tbl[6] = ln(tbl[6], 1, OP_JIRL, 32'h1C000604, i16(5'd1, 5'd5, 16'hFFFE), 32'h1C001008, 32'd0, 1'b1, 32'h1C001000);
        tbl[6] = en(tbl[6], 32'h1C000600, 32'h1C00060C, 1'b0, 1'b0, 1'b0);
        tbl[6] = en(tbl[6], 32'h1C000604, 32'h1C001000, 1'b1, 1'b1, 1'b0);
        // BL call, BEQ not taken
        tbl[7] = ln(z, 0, OP_BL, 32'h1C000700, i26(26'h100), 32'd0, 32'd0, 1'b1, 32'h1C000B00);
        tbl[7] = ln(tbl[7], 1, OP_BEQ, 32'h1C000704, i16(0, 0, 16'd1), 32'd1, 32'd2, 1'b0, 32'd0);
        tbl[7] = en(tbl[7], 32'h1C000700, 32'h1C000B00, 1'b1, 1'b1, 1'b0);
        tbl[7] = en(tbl[7], 32'h1C000704, 32'h1C000708, 1'b0, 1'b0, 1'b0);
        // right direction, wrong predicted target
        tbl[8] = ln(z, 0, OP_BNE, 32'h1C000800, i16(0, 0, 16'h10), 32'd1, 32'd2, 1'b1, 32'h1C000800);
        tbl[8] = ln(tbl[8], 1, OP_BEQ, 32'h1C000804, i16(0, 0, 16'd4), 32'd1, 32'd1, 1'b0, 32'd0);
        tbl[8] = en(tbl[8], 32'h1C000800, 32'h1C000840, 1'b1, 1'b0, 1'b0);
        tbl[8] = fl(tbl[8], 32'h1C000840, 1'b0);

        // ---------------- reset
        rst = 1'b1; flush_i = 1'b0; upd_ready_i = 1'b1;
        drive(z);
        repeat (2) step();
        check("rst_flush", 64'(flush_o), 64'd0);
        check("rst_target", 64'(flush_target_o), 64'd0);
        check("rst_lane", 64'(flush_lane_o), 64'd0);
        check("rst_link", link_o, 64'd0);
        check("rst_upd_valid", 64'(upd_valid_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        rst = 1'b0;
        step();

        // ---------------- table
        for (int i = 0; i < 9; i++) begin
            check($sformatf("v%0d_stall_pre", i), 64'(stall_o), 64'd0);
            drive(tbl[i]);
            expect_entries(tbl[i]);
            step();
            idle();
            check($sformatf("v%0d_flush", i), 64'(flush_o), 64'(tbl[i].ef));
            check($sformatf("v%0d_target", i), 64'(flush_target_o), tbl[i].ef ? 64'(tbl[i].et) : 64'd0);
            check($sformatf("v%0d_lane", i), 64'(flush_lane_o), tbl[i].ef ? 64'(tbl[i].el) : 64'd0);
            check($sformatf("v%0d_link", i), link_o, {tbl[i].pc[1] + 32'd4, tbl[i].pc[0] + 32'd4});
            step();
            check($sformatf("v%0d_flush_pulse", i), 64'(flush_o), 64'd0);
        end
        wait_drain("table");

        // ---------------- FIFO full / stall
        upd_ready_i = 1'b0;
        v = grp(32'h1C002000); drive(v); expect_entries(v); step();
        v = grp(32'h1C002008); drive(v); expect_entries(v); step();
        check("full_stall", 64'(stall_o), 64'd1);
        v = ln(z, 0, OP_BEQ, 32'h1C002010, i16(0, 0, 16'd4), 32'd7, 32'd7, 1'b0, 32'd0);
        drive(v); step();
        idle();
        check("stalled_no_flush", 64'(flush_o), 64'd0);
        check("stalled_still", 64'(stall_o), 64'd1);
        upd_ready_i = 1'b1; step(); upd_ready_i = 1'b0;
        check("one_pop_stall", 64'(stall_o), 64'd1);
        upd_ready_i = 1'b1; step(); upd_ready_i = 1'b0;
        check("two_pop_stall", 64'(stall_o), 64'd0);
        upd_ready_i = 1'b1;
        wait_drain("stall");

        // ---------------- external flush kills a mispredict
        flush_i = 1'b1; drive(tbl[0]); step();
        flush_i = 1'b0; idle();
        check("flush_i_no_flush", 64'(flush_o), 64'd0);
        drive(tbl[0]); expect_entries(tbl[0]); step();
        flush_i = 1'b1; idle();
        check("pre_flush_i_flush", 64'(flush_o), 64'd1);
        step();
        flush_i = 1'b0;
        check("flush_i_forces_low", 64'(flush_o), 64'd0);
        wait_drain("flushi");

        // ---------------- reset mid-stream with 3 entries queued
        upd_ready_i = 1'b0;
        drive(grp(32'h1C003000)); step();
        v = ln(z, 0, OP_BEQ, 32'h1C003008, i16(0, 0, 16'd2), 32'd1, 32'd2, 1'b0, 32'd0);
        drive(v); step();
        idle();
        check("pre_rst_upd_valid", 64'(upd_valid_o), 64'd1);
        rst = 1'b1; drive(tbl[0]); step();
        sb.delete();
        check("midrst_flush", 64'(flush_o), 64'd0);
        check("midrst_upd_valid", 64'(upd_valid_o), 64'd0);
        check("midrst_stall", 64'(stall_o), 64'd0);
        check("midrst_link", link_o, 64'd0);
        rst = 1'b0; idle(); upd_ready_i = 1'b1; step();
        check("post_rst_flush", 64'(flush_o), 64'd0);
        check("post_rst_upd_valid", 64'(upd_valid_o), 64'd0);
        wait_drain("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
